mul_seq_param: RTL
==================

MUL_SEQ_PARAM -- requirements
Module: mul_seq_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand width in bits; legal range 4..32.
REQ-002 The block SHALL have parameter BPC, default 1, multiplier bits processed per cycle; legal values 1, 2, 4; WIDTH SHALL be a multiple of BPC.
REQ-003 The block SHALL have port clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_ni  input  1  reset; synchronous, active-low.
REQ-005 The block SHALL have port start_i  input  1  request to begin a multiply; sampled only in IDLE.
REQ-006 The block SHALL have port signed_i  input  1  operand mode, sampled with start_i: 1 = two's complement, 0 = unsigned.
REQ-007 The block SHALL have port a_bi  input  WIDTH  multiplicand, sampled with start_i.
REQ-008 The block SHALL have port b_bi  input  WIDTH  multiplier, sampled with start_i.
REQ-009 The block SHALL have port busy_o  output  1  high while in WORK.
REQ-010 The block SHALL have port done_o  output  1  one-cycle pulse marking a new result on y_bo.
REQ-011 The block SHALL have port y_bo  output  2*WIDTH  registered product of the last completed operation.

Function
REQ-012 The FSM SHALL have two states, IDLE and WORK; busy_o = (state == WORK), decoded from the state register.
REQ-013 IDLE->WORK SHALL occur on a clock edge with start_i=1; a_bi, b_bi and signed_i are captured on that edge.
REQ-014 On capture in signed mode, operands SHALL be converted to magnitudes (WIDTH-bit unsigned; -2^(WIDTH-1) maps to 2^(WIDTH-1)), and the result-negate flag SHALL be set to sign(a) XOR sign(b); in unsigned mode the operands are used as-is and the flag is cleared.
REQ-015 On capture, the accumulator SHALL clear to 0 and the step counter SHALL clear to 0.
REQ-016 Each WORK cycle SHALL add (magnitude_a * b_mag[ctr*BPC +: BPC]) << (ctr*BPC) to the 2*WIDTH-bit accumulator, then increment ctr.
REQ-017 WORK SHALL last exactly N = WIDTH/BPC cycles; on the edge ending step N-1, state SHALL return to IDLE.
REQ-018 On that same edge, y_bo SHALL load the final sum, two's-complement negated when the negate flag is set; arithmetic is modulo 2^(2*WIDTH), with no overflow possible.
REQ-019 On that same edge, done_o SHALL be set; it is high for exactly the one following cycle.
REQ-020 Latency SHALL be N cycles: start sampled at edge k gives done_o=1 and a valid y_bo in the cycle after edge k+N.
REQ-021 y_bo SHALL hold its value until the next completion; neither start_i nor signed_i changes alone alter it.
REQ-022 start_i while in WORK SHALL be ignored; no queuing; the operation in flight is unaffected.
REQ-023 start_i in the cycle where done_o=1 SHALL be accepted (the state is IDLE), giving back-to-back throughput of one result per N+1 cycles.
REQ-024 Changes on a_bi, b_bi and signed_i outside the capture edge SHALL have no effect.

Reset
REQ-025 With rst_ni=0 at a clock edge, state SHALL become IDLE, busy_o=0, done_o=0, y_bo=0, and accumulator, counter and negate flag SHALL be 0; reset takes priority over start_i.
REQ-026 Reset during WORK SHALL abort the operation: no done_o pulse, and y_bo=0.
REQ-027 Before the first clock edge with rst_ni=0, output values are not defined; the bench SHALL apply reset first.

Verification
REQ-028 WIDTH=8, BPC=1, unsigned, a=255, b=255, start pulse -> busy_o=1 for 8 cycles, then done_o=1 for 1 cycle and y_bo=0xFE01.
REQ-029 WIDTH=8, signed: -128 * -128 -> y_bo=0x4000; -3 * 5 -> y_bo=0xFFF1; 0 * -1 -> y_bo=0x0000.
REQ-030 WIDTH=8, BPC=2, unsigned, 200 * 100 -> done_o in the cycle after edge k+4 and y_bo=0x4E20.
REQ-031 Start 7*9, then start_i=1 with a=1, b=1 during WORK -> y_bo=63 and exactly one done_o; next start in the done_o cycle with 2*3 -> y_bo=6 after a further N cycles.
REQ-032 Start 15*15, rst_ni=0 at WORK cycle 3 -> next cycle busy_o=0, done_o=0, y_bo=0; no later done_o without a new start.
REQ-033 Randomised sweep, WIDTH in {8,16}, BPC in {1,2,4}, both modes, ≥1000 operations -> y_bo equals the reference product each time, and latency always equals WIDTH/BPC.

Source files
------------

// File: rtl/mul_seq_param.sv
// ---------------------------------------------------------------------------
// mul_seq_param
//
// Purpose:
//   Sequential shift-and-add multiplier that processes BPC multiplier bits
//   per clock. An operation takes N = WIDTH/BPC cycles in WORK, then returns
//   to IDLE and loads the product into y_bo. Operands can be treated as
//   unsigned or two's complement. In signed mode the datapath works on
//   magnitudes, and the product is negated once at the end.
//
// Parameters:
//   WIDTH   operand width in bits (4..32)
//   BPC     multiplier bits consumed per cycle (1, 2 or 4); divides WIDTH
//
// Ports:
//   clk_i     input   1        single clock, rising edge
//   rst_ni    input   1        synchronous active-low reset
//   start_i   input   1        begin a multiply (sampled only in IDLE)
//   signed_i  input   1        1 = two's complement operands, 0 = unsigned
//   a_bi      input   WIDTH    multiplicand, captured with start_i
//   b_bi      input   WIDTH    multiplier, captured with start_i
//   busy_o    output  1        high while the FSM is in WORK
//   done_o    output  1        one-cycle pulse when y_bo holds a new result
//   y_bo      output  2*WIDTH  registered product of the last completed op
// ---------------------------------------------------------------------------
module mul_seq_param #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   a_bi,
  input  logic [WIDTH-1:0]   b_bi,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] y_bo
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  // The bit offset ctr*BPC never exceeds WIDTH-BPC. Two bits beyond the
  // counter width are enough to hold it for every legal BPC value.
  localparam int OW = CW + 2;
  localparam int PW = 2 * WIDTH;

  // Reject illegal parameter combinations at elaboration time.
  if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("mul_seq_param: WIDTH must be in 4..32");
  end
  if (!(BPC == 1 || BPC == 2 || BPC == 4) || (WIDTH % BPC) != 0) begin : g_bad_bpc
    $error("mul_seq_param: BPC must be 1, 2 or 4 and divide WIDTH");
  end

  typedef enum logic {
    IDLE = 1'b0,
    WORK = 1'b1
  } state_t;

  state_t          state_q,  state_d;
  logic [WIDTH-1:0] a_mag_q, a_mag_d;
  logic [WIDTH-1:0] b_mag_q, b_mag_d;
  logic            neg_q,    neg_d;
  logic [PW-1:0]   acc_q,    acc_d;
  logic [CW-1:0]   ctr_q,    ctr_d;
  logic [PW-1:0]   y_q,      y_d;
  logic            done_q,   done_d;

  // Datapath helpers for the current step.
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [OW-1:0]    bit_base;
  logic [BPC-1:0]   digit;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    sum;
  logic             last_step;

  // Operand magnitudes. Negating the most negative value wraps to itself,
  // and that bit pattern reads as 2^(WIDTH-1) when taken as unsigned,
  // which is the required magnitude.
  always_comb begin
    a_abs = a_bi;
    b_abs = b_bi;
    if (signed_i && a_bi[WIDTH-1]) begin
      a_abs = -a_bi;
    end
    if (signed_i && b_bi[WIDTH-1]) begin
      b_abs = -b_bi;
    end
  end

  // One partial product per cycle: a_mag times the current BPC-bit digit
  // of b_mag, shifted into place by the digit position.
  always_comb begin
    bit_base  = OW'(ctr_q) * OW'(BPC);
    digit     = b_mag_q[bit_base +: BPC];
    addend    = (PW'(a_mag_q) * PW'(digit)) << bit_base;
    sum       = acc_q + addend;
    last_step = (ctr_q == CW'(N - 1));
  end

  // Next-state and register updates for both FSM states.
  always_comb begin
    state_d = state_q;
    a_mag_d = a_mag_q;
    b_mag_d = b_mag_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    ctr_d   = ctr_q;
    y_d     = y_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = WORK;
          a_mag_d = a_abs;
          b_mag_d = b_abs;
          neg_d   = signed_i & (a_bi[WIDTH-1] ^ b_bi[WIDTH-1]);
          acc_d   = '0;
          ctr_d   = '0;
        end
      end
      WORK: begin
        acc_d = sum;
        ctr_d = ctr_q + CW'(1);
        if (last_step) begin
          state_d = IDLE;
          ctr_d   = '0;
          y_d     = neg_q ? -sum : sum;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. Reset wins over everything, including a pending start.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_mag_q <= '0;
      b_mag_q <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      ctr_q   <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_mag_q <= a_mag_d;
      b_mag_q <= b_mag_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      ctr_q   <= ctr_d;
      y_q     <= y_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = (state_q == WORK);
  assign done_o = done_q;
  assign y_bo   = y_q;

endmodule
